excp_redirect_ctrl: RTL

Commit-side exception and ERTN sequencer for the LoongArch pipeline. It samples exception flags and pending interrupts on the instruction at commit. It drives a one-cycle request vector into the CSR unit, then captures the CSR-computed target PC. It then flushes the pipeline and delivers that redirect to the fetch stage through a valid/ready handshake.

---
 rtl/excp_redirect_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/excp_redirect_ctrl.sv
// Commit-side exception/ERTN sequencer: issues one request to the CSR unit, captures its target PC,
// then flushes and hands the redirect to fetch over valid/ready (3 cycles minimum per event).
module excp_redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic [6:0]       commit_excp,
    input  logic [31:0]      commit_badva,
    input  logic             has_int,
    input  logic             stallreq_axi,
    input  logic [31:0]      csr_new_pc,
    output logic [63:0]      csr_vec,
    output logic [31:0]      csr_pc,
    output logic [31:0]      csr_error_va,
    output logic             flush,
    output logic             commit_stall,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic [CNT_W-1:0] excp_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_REDIR} state_t;

    state_t      state, state_nxt;
    logic        trigger;
    logic        ertn_m;
    logic        counts;
    logic [7:0]  req_vec;
    logic [31:0] req_pc;
    logic [31:0] req_va;

    assign trigger = (state == IDLE) & commit_valid & ((|commit_excp) | has_int);
    // An exception or interrupt in the same cycle takes priority over ERTN.
    assign ertn_m  = commit_excp[0] & ~(|commit_excp[6:1]) & ~has_int;
    // Pure ERTN is a return, not a taken exception.
    assign counts  = (|req_vec[7:2]) | req_vec[0];

    assign commit_stall = trigger | (state != IDLE);
    assign csr_pc       = req_pc;
    assign csr_error_va = req_va;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_vec  <= 8'd0;
            req_pc   <= 32'd0;
            req_va   <= 32'd0;
            redir_pc <= 32'd0;
            excp_cnt <= '0;
        end else begin
            if (trigger) begin
                req_vec <= {commit_excp[6:1], ertn_m, has_int};
                req_pc  <= commit_pc;
                req_va  <= commit_badva;
            end
            // The CSR drops requests during a bus stall, so only the unstalled cycle counts.
            if (state == ISSUE && !stallreq_axi) begin
                redir_pc <= csr_new_pc;
                if (counts) begin
                    excp_cnt <= excp_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        csr_vec     = 64'd0;
        flush       = 1'b0;
        redir_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                csr_vec = {56'd0, req_vec};
                flush   = 1'b1;
                if (!stallreq_axi) begin
                    state_nxt = WAIT_REDIR;
                end
            end
            WAIT_REDIR: begin
                flush       = 1'b1;
                redir_valid = 1'b1;
                if (redir_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
